// File: rtl/proto_field_extractor.sv
// proto_field_extractor: protobuf tag/length decoder with payload pass-through.
// Latency: field_id_valid one cycle after the final tag (or length) byte; payload bytes pass through combinationally.
// Backpressure: EMIT holds until field_id_rdy; pass-through byte_rdy follows data_rdy. Optional checks: PROTO_ERR_CHECK_EN.
module proto_field_extractor #(
  parameter int FIELD_ID_W = 16,
  parameter int LEN_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid,
  output logic                  byte_rdy,
  output logic [FIELD_ID_W-1:0] field_id_o,
  output logic [2:0]            wire_type_o,
  output logic [LEN_W-1:0]      field_len_o,
  output logic                  field_id_valid,
  input  logic                  field_id_rdy,
  output logic [7:0]            data_o,
  output logic                  data_valid,
  output logic                  data_last,
  input  logic                  data_rdy,
  output logic                  err_o
);

  localparam logic [2:0] S_TAG     = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_EMIT    = 3'd2;
  localparam logic [2:0] S_VARINT  = 3'd3;
  localparam logic [2:0] S_FIXED   = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

`ifdef PROTO_ERR_CHECK_EN
  // Wide tag contribution so bits beyond the field width can be detected.
  localparam int TAG_W     = 64;
  localparam int LEN_BYTES = (LEN_W + 6) / 7;
`else
  // Contribution is truncated straight to the field width.
  localparam int TAG_W     = FIELD_ID_W;
`endif

  logic [2:0]            state, state_nxt;
  logic [FIELD_ID_W-1:0] field_q;
  logic [2:0]            wt_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;
  logic [2:0]            tag_cnt;
  logic [3:0]            len_cnt;

  logic                  pass;
  logic                  accept;
  logic                  xfer;
  logic                  is_last;
  logic [5:0]            tag_off;
  logic [6:0]            len_off;
  logic [TAG_W-1:0]      tag_bits;
  logic [FIELD_ID_W-1:0] field_new;
  logic [LEN_W-1:0]      len_bits;
  logic [2:0]            wt_fin;
  logic                  proto_err;

  assign pass     = (state == S_VARINT) || (state == S_FIXED) || (state == S_PAYLOAD);
  assign accept   = byte_valid && byte_rdy;
  assign xfer     = pass && byte_valid && data_rdy;
  assign is_last  = (state == S_VARINT) ? ~byte_i[7] : (cnt_q == LEN_W'(1));

  // First tag byte carries 4 field bits; later bytes add 7 bits each starting at bit 4.
  assign tag_off  = 6'd4 + 6'(tag_cnt - 3'd1) * 6'd7;
  assign len_off  = 7'(len_cnt) * 7'd7;
  assign tag_bits = (tag_cnt == 3'd0) ? TAG_W'(byte_i[6:3]) : (TAG_W'(byte_i[6:0]) << tag_off);
  assign len_bits = LEN_W'(byte_i[6:0]) << len_off;
  assign field_new = field_q | tag_bits[FIELD_ID_W-1:0];
  assign wt_fin   = (tag_cnt == 3'd0) ? byte_i[2:0] : wt_q;

  assign byte_rdy       = pass ? data_rdy : ((state == S_TAG) || (state == S_LEN));
  assign field_id_valid = (state == S_EMIT);
  assign data_o         = byte_i;
  assign data_valid     = pass && byte_valid;
  assign data_last      = pass && byte_valid && is_last;
  assign field_id_o     = field_q;
  assign wire_type_o    = wt_q;
  assign field_len_o    = len_q;

`ifdef PROTO_ERR_CHECK_EN
  assign err_o = (state == S_ERROR);

  // Protocol violations detected on the byte being accepted in TAG or LEN.
  always_comb begin
    proto_err = 1'b0;
    if (accept && state == S_TAG) begin
      if ((tag_bits >> FIELD_ID_W) != '0) proto_err = 1'b1;
      if (tag_cnt == 3'd5)                proto_err = 1'b1;
      if (!byte_i[7] && (wt_fin == 3'd3 || wt_fin == 3'd4 || wt_fin == 3'd6 || wt_fin == 3'd7))
        proto_err = 1'b1;
      if (!byte_i[7] && field_new == '0)  proto_err = 1'b1;
    end
    if (accept && state == S_LEN && len_cnt == 4'(LEN_BYTES)) proto_err = 1'b1;
  end
`else
  assign err_o     = 1'b0;
  assign proto_err = 1'b0;
`endif

  // Next-state selection for the parser.
  always_comb begin
    state_nxt = state;
    case (state)
      S_TAG:     if (accept && !byte_i[7]) state_nxt = (wt_fin == 3'd2) ? S_LEN : S_EMIT;
      S_LEN:     if (accept && !byte_i[7]) state_nxt = S_EMIT;
      S_EMIT: begin
        if (field_id_rdy) begin
          case (wt_q)
            3'd0:    state_nxt = S_VARINT;
            3'd1,
            3'd5:    state_nxt = S_FIXED;
            3'd2:    state_nxt = (len_q != '0) ? S_PAYLOAD : S_TAG;
            default: state_nxt = S_TAG;
          endcase
        end
      end
      S_VARINT,
      S_FIXED,
      S_PAYLOAD: if (xfer && is_last) state_nxt = S_TAG;
      S_ERROR:   state_nxt = S_ERROR;
      default:   state_nxt = S_TAG;
    endcase
    if (proto_err) state_nxt = S_ERROR;
  end

  // State, accumulators and beat counter; accumulators clear whenever TAG is re-entered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= S_TAG;
      field_q <= '0;
      wt_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tag_cnt <= '0;
      len_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TAG && state != S_TAG) begin
        field_q <= '0;
        wt_q    <= '0;
        len_q   <= '0;
        tag_cnt <= '0;
        len_cnt <= '0;
      end else begin
        if (state == S_TAG && accept) begin
          field_q <= field_new;
          wt_q    <= wt_fin;
          tag_cnt <= (tag_cnt == 3'd7) ? tag_cnt : tag_cnt + 3'd1;
        end
        if (state == S_LEN && accept) begin
          len_q   <= len_q | len_bits;
          len_cnt <= (len_cnt == 4'd15) ? len_cnt : len_cnt + 4'd1;
        end
      end
      if (state == S_EMIT && field_id_rdy)
        cnt_q <= (wt_q == 3'd1) ? LEN_W'(8) : (wt_q == 3'd5) ? LEN_W'(4) : len_q;
      else if (xfer && state != S_VARINT)
        cnt_q <= cnt_q - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_proto_field_extractor.sv
// Bench for proto_field_extractor: directed byte streams, protobuf-level reference model, per-cycle compare.
// Timing: inputs change on the falling edge, outputs sampled 2 time units later.
// Backpressure: data_rdy randomised in selected tests, field_id_rdy stalled explicitly.
module tb_proto_field_extractor;
  localparam int FW = 16;
  localparam int LW = 32;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [7:0]    byte_i;
  logic          byte_valid;
  logic          byte_rdy;
  logic [FW-1:0] field_id_o;
  logic [2:0]    wire_type_o;
  logic [LW-1:0] field_len_o;
  logic          field_id_valid;
  logic          field_id_rdy;
  logic [7:0]    data_o;
  logic          data_valid;
  logic          data_last;
  logic          data_rdy;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  proto_field_extractor #(.FIELD_ID_W(FW), .LEN_W(LW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .byte_i(byte_i), .byte_valid(byte_valid),
    .byte_rdy(byte_rdy), .field_id_o(field_id_o), .wire_type_o(wire_type_o),
    .field_len_o(field_len_o), .field_id_valid(field_id_valid), .field_id_rdy(field_id_rdy),
    .data_o(data_o), .data_valid(data_valid), .data_last(data_last), .data_rdy(data_rdy),
    .err_o(err_o)
  );

  typedef struct {
    longint unsigned fid;
    longint unsigned wt;
    longint unsigned len;
  } rec_t;

  rec_t       exp_rec[$];
  logic [8:0] exp_dat[$];   // {last, byte}
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic       rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: standard protobuf decoding of a whole well-formed byte stream.
  task automatic model(input logic [7:0] b[$]);
    int i;
    int sh;
    int n;
    longint unsigned v;
    longint unsigned l;
    logic [7:0] x;
    rec_t r;
    i = 0;
    while (i < b.size()) begin
      v = 0; sh = 0;
      do begin x = b[i]; i++; v = v | (64'(x[6:0]) << sh); sh += 7; end while (x[7]);
      r.fid = (v >> 3) & ((64'd1 << FW) - 1);
      r.wt  = v & 7;
      r.len = 0;
      if (r.wt == 2) begin
        l = 0; sh = 0;
        do begin x = b[i]; i++; l = l | (64'(x[6:0]) << sh); sh += 7; end while (x[7]);
        r.len = l & ((64'd1 << LW) - 1);
      end
      exp_rec.push_back(r);
      if (r.wt == 0) begin
        do begin x = b[i]; i++; exp_dat.push_back({~x[7], x}); end while (x[7]);
      end else begin
        n = (r.wt == 1) ? 8 : (r.wt == 5) ? 4 : (r.wt == 2) ? int'(r.len) : 0;
        for (int k = 0; k < n; k++) begin
          exp_dat.push_back({(k == n - 1), b[i]});
          i++;
        end
      end
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Payload consumer readiness.
  initial begin
    data_rdy = 1'b1;
    forever begin
      @(negedge clk_i);
      data_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Per-cycle compare against the model queues.
  initial begin
    rec_t r;
    logic [8:0] e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!reset_i) begin
        chk("valid_exclusive", {63'd0, field_id_valid & data_valid}, 64'd0);
        if (field_id_valid && field_id_rdy) begin
          if (exp_rec.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_record: got field %0d, expected none", field_id_o);
          end else begin
            r = exp_rec.pop_front();
            chk("rec_field_id", 64'(field_id_o), r.fid);
            chk("rec_wire_type", 64'(wire_type_o), r.wt);
            chk("rec_len", 64'(field_len_o), r.len);
          end
        end
        if (data_valid && data_rdy) begin
          if (exp_dat.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_data: got 0x%0h, expected none", data_o);
          end else begin
            e = exp_dat.pop_front();
            chk("data_beat", 64'({data_last, data_o}), 64'(e));
          end
        end
      end
    end
  end

  // Present one byte and return on the falling edge after it was accepted.
  task automatic send(input logic [7:0] b, output int acc_cyc);
    int g;
    g = 0;
    byte_i = b;
    byte_valid = 1'b1;
    #1;
    while (!byte_rdy && g < 200) begin
      @(negedge clk_i); #1; g++;
    end
    if (g >= 200) begin
      tests++; fails++;
      $display("FAIL send_timeout: byte 0x%0h got no byte_rdy, expected acceptance", b);
    end
    acc_cyc = cyc;
    @(negedge clk_i);
    byte_valid = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] q[$]);
    int a;
    foreach (q[k]) send(q[k], a);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_rec.size() != 0 || exp_dat.size() != 0) && g < 200) begin
      @(negedge clk_i); g++;
    end
    chk({name, "_recs_left"}, 64'(exp_rec.size()), 64'd0);
    chk({name, "_data_left"}, 64'(exp_dat.size()), 64'd0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_field_id_valid"}, 64'(field_id_valid), 64'd0);
    chk({name, "_field_id"}, 64'(field_id_o), 64'd0);
    chk({name, "_wire_type"}, 64'(wire_type_o), 64'd0);
    chk({name, "_field_len"}, 64'(field_len_o), 64'd0);
    chk({name, "_err"}, 64'(err_o), 64'd0);
    chk({name, "_data_valid"}, 64'(data_valid), 64'd0);
    chk({name, "_data_last"}, 64'(data_last), 64'd0);
    chk({name, "_byte_rdy"}, 64'(byte_rdy), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    #2;
  endtask

  initial begin
    logic [7:0] q[$];
    int a0, a1;
    reset_i = 1'b1;
    byte_i = 8'h00;
    byte_valid = 1'b0;
    field_id_rdy = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    #2;
    check_reset("reset");

    // Varint field 1 = 150.
    q = '{8'h08, 8'h96, 8'h01};
    model(q);
    chk("model_t1_fid", exp_rec[0].fid, 64'd1);
    chk("model_t1_wt", exp_rec[0].wt, 64'd0);
    chk("model_t1_last", 64'(exp_dat[1]), 64'h101);
    send(8'h08, a0);
    #2;
    chk("t1_valid_next_cycle", 64'(field_id_valid), 64'd1);
    chk("t1_byte_rdy_emit", 64'(byte_rdy), 64'd0);
    send(8'h96, a0);
    send(8'h01, a0);
    drain("t1");
    #2;
    chk("t1_back_to_tag", 64'(byte_rdy), 64'd1);

    // Length-delimited "abc" with a stuttering consumer.
    rdy_rand = 1'b1;
    q = '{8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
    model(q);
    chk("model_t2_len", exp_rec[0].len, 64'd3);
    chk("model_t2_last", 64'(exp_dat[2]), 64'h163);
    send_all(q);
    drain("t2");
    rdy_rand = 1'b0;

    // Field 16, empty payload, then an immediate next tag.
    q = '{8'h82, 8'h01, 8'h00};
    model(q);
    chk("model_t3_fid", exp_rec[0].fid, 64'd16);
    chk("model_t3_len", exp_rec[0].len, 64'd0);
    send(8'h82, a0);
    send(8'h01, a0);
    send(8'h00, a0);
    q = '{8'h08, 8'h01};
    model(q);
    send(8'h08, a1);
    chk("t3_tag_spacing", 64'(a1 - a0), 64'd2);
    send(8'h01, a1);
    drain("t3");

    // Fixed32 with downstream stalled for 5 cycles.
    field_id_rdy = 1'b0;
    q = '{8'h0D, 8'h01, 8'h02, 8'h03, 8'h04};
    model(q);
    chk("model_t4_wt", exp_rec[0].wt, 64'd5);
    send(8'h0D, a0);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("t4_stall_valid", 64'(field_id_valid), 64'd1);
      chk("t4_stall_fid", 64'(field_id_o), 64'd1);
      chk("t4_stall_byte_rdy", 64'(byte_rdy), 64'd0);
      @(negedge clk_i);
    end
    field_id_rdy = 1'b1;
    q.delete(0);
    send_all(q);
    drain("t4");

    // Wire type 3.
`ifdef PROTO_ERR_CHECK_EN
    send(8'h0B, a0);
    #2;
    chk("t5_err", 64'(err_o), 64'd1);
    chk("t5_byte_rdy", 64'(byte_rdy), 64'd0);
    chk("t5_no_valid", 64'(field_id_valid), 64'd0);
    repeat (3) @(negedge clk_i);
    #2;
    chk("t5_err_held", 64'(err_o), 64'd1);
    chk("t5_byte_rdy_held", 64'(byte_rdy), 64'd0);
    pulse_reset();
    check_reset("t5_after_reset");
`else
    q = '{8'h0B};
    model(q);
    chk("model_t5_wt", exp_rec[0].wt, 64'd3);
    send(8'h0B, a0);
    drain("t5");
    #2;
    chk("t5_back_to_tag", 64'(byte_rdy), 64'd1);
    chk("t5_err_tied", 64'(err_o), 64'd0);
`endif

    // Reset in the middle of a payload.
    q = '{8'h12, 8'h05, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    model(q);
    send_all('{8'h12, 8'h05, 8'h61, 8'h62});
    chk("t6_pending_beats", 64'(exp_dat.size()), 64'd3);
    pulse_reset();
    check_reset("t6_after_reset");
    exp_dat.delete();
    exp_rec.delete();
    q = '{8'h08, 8'h01};
    model(q);
    send_all(q);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
